mul_seq_ctrl: RTL and testbench
===============================

// Module: mul_seq_ctrl
// PURPOSE
//  Multicycle unsigned shift-add multiplier sequencer.
//  Time-shares one N-bit lookahead adder (adder_la4) across N iterations,
//  replacing the large combinational array multiplier for area-constrained cpu builds.
//  Sits beside alu32 as an extended-op unit.
//  Operands enter and results leave via valid/ready handshakes.
// PARAMETERS
//  N  32  operand width; multiple of 4 (adder_la4 constraint); N>=4
// PORTS
//  clk          in   1     rising-edge clock
//  rst          in   1     synchronous active-high reset
//  start_valid  in   1     operands a,b valid
//  start_ready  out  1     unit can accept operands (high only in IDLE)
//  a            in   N     multiplicand, unsigned
//  b            in   N     multiplier, unsigned
//  res_valid    out  1     y holds a valid product (high only in DONE)
//  res_ready    in   1     consumer accepts y
//  y            out  2N    product a*b, unsigned
//  busy         out  1     high in RUN
// BEHAVIOUR
//  - One clock (clk), synchronous active-high reset (rst); all state updates on posedge clk.
//  - Reset: state=IDLE, start_ready=1, res_valid=0, busy=0, y=0, acc=0, cnt=0.
//    rst has priority over every other input, including mid-RUN; any partial product is discarded.
//  - Registers:
//    - mcand[N-1:0]
//    - acc[N:0]: upper half plus carry
//    - q[N-1:0]: multiplier, becoming the lower product half
//    - cnt: clog2(N+1) bits
//  - FSM:
//    - IDLE: on start_valid && start_ready, latch mcand=a, q=b, acc=0, cnt=N; go to RUN.
//    - RUN, each cycle:
//      - addend = q[0] ? mcand : 0.
//      - {c,sum} = acc[N-1:0] + addend, computed by one adder_la4 instance (cin=0).
//      - {acc,q} <= {c,sum,q} >> 1, i.e. acc={1'b0,c,sum[N-1:1]}, q={sum[0],q[N-1:1]}.
//      - cnt <= cnt-1.
//      - When cnt==1 this is the final step: next state DONE, and y <= final {acc[N-1:0],q}.
//    - DONE: res_valid=1, y held stable.
//      - On res_ready, go to IDLE next cycle.
//      - If res_ready is low, hold indefinitely (backpressure); y and res_valid must not change.
//  - Latency:
//    - Handshake edge at cycle k; RUN steps on edges k+1..k+N.
//    - res_valid is high from cycle k+N+1.
//    - Fixed; no early termination for zero operands.
//  - Throughput:
//    - start_ready is low in RUN and DONE; start_valid there is ignored and not queued.
//    - Earliest next accept is the cycle after the res handshake.
//    - Back-to-back period: N+2 cycles.
//  - Simultaneous events:
//    - In DONE, res_ready together with start_valid: result consumed, start NOT accepted this cycle.
//    - rst concurrent with any handshake: rst wins; no handshake occurs.
//  - Widths:
//    - Product is exact and cannot overflow 2N bits.
//    - The carry c never propagates beyond acc[N-1] after the shift; acc[N] is always 0 post-shift.
//  - a and b are sampled only at the accept edge; later changes have no effect.
//  - y is cleared to 0 only by rst; it keeps the last product while in IDLE.
// TESTING
//  1. N=32, a=3, b=5 -> res_valid exactly 33 cycles after accept edge, y=64'd15.
//  2. N=32, a=b=32'hFFFFFFFF -> y=64'hFFFFFFFE00000001.
//     a=0, b=32'h12345678 -> y=0, same latency.
//  3. Backpressure: hold res_ready=0 for 10 cycles after res_valid -> y, res_valid stable,
//     start_ready=0; release -> IDLE next cycle.
//  4. Pulse start_valid with a=7, b=9 during RUN -> ignored; only the original product is
//     returned, then 7*9=63 is accepted after the next IDLE.
//  5. Assert rst at RUN step 10 -> next cycle IDLE, busy=0, y=0; then 6*7 -> y=42 with full latency.
//  6. N=8, a=8'hFF, b=8'hFF -> y=16'hFE01 after 9 cycles.
//     Random sweep of 1000 pairs checked against a*b.

Source files
------------

// File: rtl/mul_seq_ctrl.sv
// ============================================================================
// Module   : mul_seq_ctrl (with helper adder_la4)
// Purpose  : Multicycle unsigned shift-add multiplier sharing one N-bit adder.
// Revision : 1.0
// ============================================================================
`default_nettype none

module adder_la4 #(
  parameter int N = 32
) (
  input  logic [N-1:0] a_i,
  input  logic [N-1:0] b_i,
  input  logic         cin_i,
  output logic [N-1:0] sum_o,
  output logic         cout_o
);

  logic [N-1:0] w_g;
  logic [N-1:0] w_p;
  logic [N-1:0] w_carry;
  logic [3:0]   w_g4;
  logic [3:0]   w_p4;
  logic         w_cg;
  logic         w_c1;
  logic         w_c2;
  logic         w_c3;

  assign w_g = a_i & b_i;
  assign w_p = a_i ^ b_i;

  // Full lookahead inside each 4-bit group; group carries ripple between groups.
  always_comb begin
    w_carry = '0;
    w_g4    = '0;
    w_p4    = '0;
    w_c1    = 1'b0;
    w_c2    = 1'b0;
    w_c3    = 1'b0;
    w_cg    = cin_i;
    for (int i = 0; i < N / 4; i++) begin
      w_g4 = w_g[4*i +: 4];
      w_p4 = w_p[4*i +: 4];
      w_c1 = w_g4[0] | (w_p4[0] & w_cg);
      w_c2 = w_g4[1] | (w_p4[1] & w_g4[0]) | (w_p4[1] & w_p4[0] & w_cg);
      w_c3 = w_g4[2] | (w_p4[2] & w_g4[1]) | (w_p4[2] & w_p4[1] & w_g4[0])
           | (w_p4[2] & w_p4[1] & w_p4[0] & w_cg);
      w_carry[4*i +: 4] = {w_c3, w_c2, w_c1, w_cg};
      w_cg = w_g4[3] | (w_p4[3] & w_g4[2]) | (w_p4[3] & w_p4[2] & w_g4[1])
           | (w_p4[3] & w_p4[2] & w_p4[1] & w_g4[0])
           | (w_p4[3] & w_p4[2] & w_p4[1] & w_p4[0] & w_cg);
    end
  end

  assign sum_o  = w_p ^ w_carry;
  assign cout_o = w_cg;

endmodule

module mul_seq_ctrl #(
  parameter int N = 32
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start_valid,
  output logic           start_ready,
  input  logic [N-1:0]   a,
  input  logic [N-1:0]   b,
  output logic           res_valid,
  input  logic           res_ready,
  output logic [2*N-1:0] y,
  output logic           busy
);

  localparam int CW = $clog2(N + 1);
  localparam logic [CW-1:0] CNT_INIT = CW'(N);
  localparam logic [CW-1:0] CNT_LAST = CW'(1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e         state_q, state_d;
  logic [N-1:0]   mcand_q, mcand_d;
  // Upper product half; the adder carry is folded in by the shift, so the
  // extra top bit of the accumulator would always read zero and is not kept.
  logic [N-1:0]   acc_q, acc_d;
  logic [N-1:0]   q_q, q_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [2*N-1:0] y_q, y_d;

  logic [N-1:0]   w_addend;
  logic [N-1:0]   w_sum;
  logic           w_cout;

  assign w_addend = q_q[0] ? mcand_q : '0;

  adder_la4 #(.N(N)) u_adder (
    .a_i    (acc_q),
    .b_i    (w_addend),
    .cin_i  (1'b0),
    .sum_o  (w_sum),
    .cout_o (w_cout)
  );

  always_comb begin
    state_d     = state_q;
    mcand_d     = mcand_q;
    acc_d       = acc_q;
    q_d         = q_q;
    cnt_d       = cnt_q;
    y_d         = y_q;
    start_ready = 1'b0;
    res_valid   = 1'b0;
    busy        = 1'b0;
    case (state_q)
      S_IDLE: begin
        start_ready = 1'b1;
        if (start_valid) begin
          mcand_d = a;
          q_d     = b;
          acc_d   = '0;
          cnt_d   = CNT_INIT;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        busy  = 1'b1;
        acc_d = {w_cout, w_sum[N-1:1]};
        q_d   = {w_sum[0], q_q[N-1:1]};
        cnt_d = cnt_q - CNT_LAST;
        if (cnt_q == CNT_LAST) begin
          y_d     = {w_cout, w_sum, q_q[N-1:1]};
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        res_valid = 1'b1;
        if (res_ready) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      mcand_q <= '0;
      acc_q   <= '0;
      q_q     <= '0;
      cnt_q   <= '0;
      y_q     <= '0;
    end else begin
      state_q <= state_d;
      mcand_q <= mcand_d;
      acc_q   <= acc_d;
      q_q     <= q_d;
      cnt_q   <= cnt_d;
      y_q     <= y_d;
    end
  end

  assign y = y_q;

endmodule

`default_nettype wire

// File: tb/tb_mul_seq_ctrl.sv
// ============================================================================
// Module   : tb_mul_seq_ctrl
// Purpose  : Directed vector table plus corner-case sequences for N=32 and N=8.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_mul_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  always #5 clk = ~clk;

  logic        sv32, sr32, rv32, rr32, busy32;
  logic [31:0] a32, b32;
  logic [63:0] y32;

  logic        sv8, sr8, rv8, rr8, busy8;
  logic [7:0]  a8, b8;
  logic [15:0] y8;

  mul_seq_ctrl #(.N(32)) dut32 (
    .clk(clk), .rst(rst), .start_valid(sv32), .start_ready(sr32), .a(a32), .b(b32),
    .res_valid(rv32), .res_ready(rr32), .y(y32), .busy(busy32)
  );

  mul_seq_ctrl #(.N(8)) dut8 (
    .clk(clk), .rst(rst), .start_valid(sv8), .start_ready(sr8), .a(a8), .b(b8),
    .res_valid(rv8), .res_ready(rr8), .y(y8), .busy(busy8)
  );

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] y;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // lat counts edges after the accept edge until res_valid is seen high (N expected).
  task automatic wait_res32(inout int lat);
    while (!rv32 && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic mul32(input logic [31:0] a, input logic [31:0] b,
                       output logic [63:0] yo, output int lat);
    a32 = a; b32 = b; sv32 = 1'b1;
    @(posedge clk); #1;
    sv32 = 1'b0;
    lat = 0;
    wait_res32(lat);
    yo = y32;
    rr32 = 1'b1;
    @(posedge clk); #1;
    rr32 = 1'b0;
  endtask

  task automatic mul8(input logic [7:0] a, input logic [7:0] b,
                      output logic [15:0] yo, output int lat);
    a8 = a; b8 = b; sv8 = 1'b1;
    @(posedge clk); #1;
    sv8 = 1'b0;
    lat = 0;
    while (!rv8 && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    yo = y8;
    rr8 = 1'b1;
    @(posedge clk); #1;
    rr8 = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] yr;
    logic [15:0] yr8;
    logic [7:0]  ra, rb;
    int          lat;

    vecs[0] = '{32'd3,          32'd5,          64'd15};
    vecs[1] = '{32'hFFFFFFFF,   32'hFFFFFFFF,   64'hFFFFFFFE00000001};
    vecs[2] = '{32'd0,          32'h12345678,   64'd0};
    vecs[3] = '{32'd1,          32'hFFFFFFFF,   64'h00000000FFFFFFFF};
    vecs[4] = '{32'hFFFFFFFF,   32'd2,          64'h00000001FFFFFFFE};
    vecs[5] = '{32'h80000000,   32'd2,          64'h0000000100000000};
    vecs[6] = '{32'h00010000,   32'h00010000,   64'h0000000100000000};
    vecs[7] = '{32'h0000FFFF,   32'h0000FFFF,   64'h00000000FFFE0001};

    rst = 1'b1;
    sv32 = 1'b0; rr32 = 1'b0; a32 = '0; b32 = '0;
    sv8  = 1'b0; rr8  = 1'b0; a8  = '0; b8  = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_start_ready", sr32, 1);
    chk("rst_res_valid", rv32, 0);
    chk("rst_busy", busy32, 0);
    chk("rst_y", y32, 0);
    rst = 1'b0;

    for (int i = 0; i < 8; i++) begin
      mul32(vecs[i].a, vecs[i].b, yr, lat);
      chk($sformatf("vec%0d_y", i), yr, vecs[i].y);
      chk($sformatf("vec%0d_lat", i), lat, 32);
    end

    // Backpressure, then simultaneous res_ready + start_valid in DONE.
    a32 = 32'd3; b32 = 32'd5; sv32 = 1'b1;
    @(posedge clk); #1;
    sv32 = 1'b0;
    lat = 0;
    wait_res32(lat);
    chk("bp_lat", lat, 32);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      chk("bp_res_valid", rv32, 1);
      chk("bp_y", y32, 64'd15);
      chk("bp_start_ready", sr32, 0);
    end
    a32 = 32'd7; b32 = 32'd9; rr32 = 1'b1; sv32 = 1'b1;
    @(posedge clk); #1;
    rr32 = 1'b0;
    chk("sim_idle_ready", sr32, 1);
    chk("sim_not_busy", busy32, 0);
    chk("sim_res_valid", rv32, 0);
    @(posedge clk); #1;
    sv32 = 1'b0;
    chk("sim_accept_busy", busy32, 1);
    lat = 0;
    wait_res32(lat);
    chk("sim_y", y32, 64'd63);
    rr32 = 1'b1;
    @(posedge clk); #1;
    rr32 = 1'b0;

    // start_valid pulsed during RUN with new operands must be ignored.
    a32 = 32'd100; b32 = 32'd200; sv32 = 1'b1;
    @(posedge clk); #1;
    sv32 = 1'b0;
    chk("run_busy", busy32, 1);
    chk("run_start_ready", sr32, 0);
    repeat (5) @(posedge clk);
    #1;
    a32 = 32'd7; b32 = 32'd9; sv32 = 1'b1;
    @(posedge clk); #1;
    sv32 = 1'b0; a32 = 32'd0; b32 = 32'd0;
    lat = 6;
    wait_res32(lat);
    chk("pulse_lat", lat, 32);
    chk("pulse_y", y32, 64'd20000);
    rr32 = 1'b1;
    @(posedge clk); #1;
    rr32 = 1'b0;
    chk("pulse_not_queued", busy32, 0);
    mul32(32'd7, 32'd9, yr, lat);
    chk("after_pulse_y", yr, 64'd63);

    // Reset in the middle of RUN: 9 steps done, rst lands on step 10.
    a32 = 32'd11; b32 = 32'd13; sv32 = 1'b1;
    @(posedge clk); #1;
    sv32 = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("midrst_busy", busy32, 0);
    chk("midrst_start_ready", sr32, 1);
    chk("midrst_res_valid", rv32, 0);
    chk("midrst_y", y32, 0);
    mul32(32'd6, 32'd7, yr, lat);
    chk("midrst_6x7_y", yr, 64'd42);
    chk("midrst_6x7_lat", lat, 32);
    repeat (3) @(posedge clk);
    #1;
    chk("idle_hold_y", y32, 64'd42);

    // N=8 instance.
    mul8(8'hFF, 8'hFF, yr8, lat);
    chk("n8_ff_y", yr8, 16'hFE01);
    chk("n8_ff_lat", lat, 8);
    for (int i = 0; i < 1000; i++) begin
      ra = 8'($urandom_range(0, 255));
      rb = 8'($urandom_range(0, 255));
      mul8(ra, rb, yr8, lat);
      chk($sformatf("n8_rand_%0h_%0h", ra, rb), yr8, 16'(ra) * 16'(rb));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
